matrix_mac_engine: RTL and testbench

MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

---
 rtl/matrix_mac_engine_pkg.sv | 23 ++
 rtl/matrix_mac_engine_mac.sv | 32 +++
 rtl/matrix_mac_engine.sv | 203 ++++++++++++++++++++
 tb/tb_matrix_mac_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mac_engine_pkg.sv
// Shared definitions for the matrix multiply-accumulate engine.
//   state_t : controller states, also exported on the engine's debug port
//   clog2   : elaboration-time ceil(log2(value)), used for width derivation
package mm_pkg;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    CHECK  = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/matrix_mac_engine_mac.sv
// Single signed multiply-accumulate lane.
//   clk, rst : clock, asynchronous active-high reset
//   en       : update the accumulator with this cycle's sum
//   clr      : start a new dot product (ignore the old accumulator)
//   a, b     : signed DW-bit operands
//   sum      : combinational (clr ? 0 : acc) + a*b, AW bits, wraps on overflow
module mm_mac #(
  parameter int DW = 8,
  parameter int AW = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] sum
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc;

  assign prod = a * b;
  // Size cast of a signed product sign-extends into the accumulator width.
  assign sum  = (clr ? '0 : acc) + AW'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (en) acc <= sum;
  end

endmodule

// File: rtl/matrix_mac_engine.sv
// Streaming matrix multiplier: loads A then B row-major, checks shapes, then
// emits C = A*B row-major, one multiply-accumulate per cycle.
//
// Handshake: a beat (in_data/col_end/row_end) is taken on a rising edge only
// when in_valid=1 and busy=0; there is no backpressure on the result side, an
// element is presented for exactly the one cycle out_valid=1.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : qualifies in_data, col_end, row_end
//   in_data       : signed DW-bit element
//   col_end       : element closes its row; with row_end it closes the matrix
//   busy          : inputs ignored while high (CHECK, CALC, DONE)
//   out_valid     : out_data/is_legal/change_row valid
//   out_data      : signed AW-bit result element
//   is_legal      : 0 marks the single rejection pulse
//   change_row    : last element of a result row
//   done          : one-cycle pulse after the final result of a job
//   dbg_state     : current controller state
module matrix_mac_engine
  import mm_pkg::*;
#(
  parameter int DW   = 8,
  parameter int MAXN = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [DW-1:0]                      in_data,
  input  logic                               col_end,
  input  logic                               row_end,
  output logic                               busy,
  output logic                               out_valid,
  output logic [2*DW+mm_pkg::clog2(MAXN)-1:0] out_data,
  output logic                               is_legal,
  output logic                               change_row,
  output logic                               done,
  output logic [2:0]                         dbg_state
);

  localparam int AW = 2 * DW + clog2(MAXN);
  localparam int IW = clog2(MAXN);      // element index width
  localparam int CW = IW + 1;           // count width, holds MAXN+1
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] NMAX = CW'(MAXN);

  state_t state;

  logic signed [DW-1:0] a_mem [MAXN][MAXN];
  logic signed [DW-1:0] b_mem [MAXN][MAXN];

  // Running load counters, shared by A and B.
  logic [CW-1:0] ld_r, ld_c, ld_cols;
  logic          ld_err;
  // Latched operand shapes.
  logic [CW-1:0] a_rows, a_cols, b_rows, b_cols;
  logic          a_err, b_err;
  // Calculation indices.
  logic [IW-1:0] i_idx, j_idx, k_idx;

  logic          accept, in_rng, beat_err, err_nxt, last_beat;
  logic [CW-1:0] row_len, rows_nxt, cols_nxt;
  logic          k_last, j_last, i_last;
  logic signed [AW-1:0] mac_sum;

  assign busy      = (state != LOAD_A) && (state != LOAD_B);
  assign dbg_state = state;

  always_comb begin
    accept    = in_valid && !busy;
    in_rng    = (ld_r < NMAX) && (ld_c < NMAX);
    row_len   = ld_c + ONE;
    // Out-of-range beats and rows whose length differs from row 0 poison the matrix.
    beat_err  = !in_rng || (col_end && (ld_r != '0) && (row_len != ld_cols));
    err_nxt   = ld_err || beat_err;
    rows_nxt  = (ld_r < NMAX) ? ld_r + ONE : ld_r;
    cols_nxt  = (ld_r == '0) ? row_len : ld_cols;
    last_beat = col_end && row_end;
    k_last    = ({1'b0, k_idx} == a_cols - ONE);
    j_last    = ({1'b0, j_idx} == b_cols - ONE);
    i_last    = ({1'b0, i_idx} == a_rows - ONE);
  end

  // Element storage has no reset; discarded beats never reach it.
  always_ff @(posedge clk) begin
    if (accept && in_rng) begin
      if (state == LOAD_A) a_mem[ld_r[IW-1:0]][ld_c[IW-1:0]] <= in_data;
      else                 b_mem[ld_r[IW-1:0]][ld_c[IW-1:0]] <= in_data;
    end
  end

  mm_mac #(.DW(DW), .AW(AW)) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (state == CALC),
    .clr (k_idx == '0),
    .a   (a_mem[i_idx][k_idx]),
    .b   (b_mem[k_idx][j_idx]),
    .sum (mac_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD_A;
      ld_r       <= '0;
      ld_c       <= '0;
      ld_cols    <= '0;
      ld_err     <= 1'b0;
      a_rows     <= '0;
      a_cols     <= '0;
      b_rows     <= '0;
      b_cols     <= '0;
      a_err      <= 1'b0;
      b_err      <= 1'b0;
      i_idx      <= '0;
      j_idx      <= '0;
      k_idx      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      is_legal   <= 1'b0;
      change_row <= 1'b0;
      done       <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      is_legal   <= 1'b0;
      change_row <= 1'b0;
      done       <= 1'b0;
      case (state)
        LOAD_A, LOAD_B: begin
          if (accept) begin
            if (last_beat) begin
              if (state == LOAD_A) begin
                a_rows <= rows_nxt;
                a_cols <= cols_nxt;
                a_err  <= err_nxt;
                state  <= LOAD_B;
              end else begin
                b_rows <= rows_nxt;
                b_cols <= cols_nxt;
                b_err  <= err_nxt;
                state  <= CHECK;
              end
              ld_r    <= '0;
              ld_c    <= '0;
              ld_cols <= '0;
              ld_err  <= 1'b0;
            end else if (col_end) begin
              ld_r    <= rows_nxt;
              ld_c    <= '0;
              ld_cols <= cols_nxt;
              ld_err  <= err_nxt;
            end else begin
              ld_c   <= (ld_c < NMAX) ? ld_c + ONE : ld_c;
              ld_err <= err_nxt;
            end
          end
        end
        CHECK: begin
          i_idx <= '0;
          j_idx <= '0;
          k_idx <= '0;
          if (a_err || b_err || (a_cols != b_rows)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          if (k_last) begin
            out_valid  <= 1'b1;
            is_legal   <= 1'b1;
            out_data   <= mac_sum;
            change_row <= j_last;
            k_idx      <= '0;
            if (j_last) begin
              j_idx <= '0;
              if (i_last) state <= DONE;
              else        i_idx <= i_idx + 1'b1;
            end else begin
              j_idx <= j_idx + 1'b1;
            end
          end else begin
            k_idx <= k_idx + 1'b1;
          end
        end
        DONE: begin
          done   <= 1'b1;
          a_err  <= 1'b0;
          b_err  <= 1'b0;
          ld_r   <= '0;
          ld_c   <= '0;
          ld_cols <= '0;
          ld_err <= 1'b0;
          state  <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mac_engine.sv
module tb_matrix_mac_engine;

  localparam int DW   = 8;
  localparam int MAXN = 4;
  localparam int AW   = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          col_end  = 1'b0;
  logic          row_end  = 1'b0;
  logic          busy, out_valid, is_legal, change_row, done;
  logic [AW-1:0] out_data;
  logic [2:0]    dbg_state;

  matrix_mac_engine #(.DW(DW), .MAXN(MAXN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .col_end    (col_end),
    .row_end    (row_end),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .is_legal   (is_legal),
    .change_row (change_row),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_rise = 0, first_ov = 0, last_ov = 0, done_cyc = 0;
  int done_cnt = 0, idle_viol = 0;
  bit got_first = 1'b0, busy_q = 1'b0;

  logic [AW-1:0] exp_q[$];
  bit            exp_cr[$];
  bit            exp_legal;
  logic [AW-1:0] obs_d[$];
  bit            obs_cr[$];
  bit            obs_lg[$];

  typedef struct {
    int d;
    bit ce;
    bit re;
  } beat_t;
  beat_t beat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (busy && !busy_q) busy_rise = cyc;
    busy_q = busy;
    if (out_valid) begin
      obs_d.push_back(out_data);
      obs_cr.push_back(change_row);
      obs_lg.push_back(is_legal);
      if (!got_first) begin
        first_ov  = cyc;
        got_first = 1'b1;
      end
      last_ov = cyc;
    end else if (out_data !== '0 || change_row !== 1'b0 || is_legal !== 1'b0) begin
      idle_viol++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input bit ce, input bit re);
    beat_t b;
    b.d = d; b.ce = ce; b.re = re;
    beat_q.push_back(b);
  endtask

  task automatic push_const(input int rows, input int cols, input int v);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        push(v, c == cols - 1, (c == cols - 1) && (r == rows - 1));
  endtask

  task automatic expect_el(input int v, input bit cr);
    exp_q.push_back(AW'(v));
    exp_cr.push_back(cr);
  endtask

  task automatic clear_job();
    exp_q.delete(); exp_cr.delete();
    obs_d.delete(); obs_cr.delete(); obs_lg.delete();
    got_first = 1'b0;
    done_cnt  = 0;
  endtask

  // Drives the queued beats; optional idle gaps carry junk on the qualified lines.
  task automatic send_beats(input bit gaps);
    @(negedge clk);
    while (beat_q.size() > 0) begin
      beat_t b;
      b = beat_q.pop_front();
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = DW'($urandom_range(0, 255));
          col_end  = 1'($urandom_range(0, 1));
          row_end  = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = DW'(b.d);
      col_end  = b.ce;
      row_end  = b.re;
      @(negedge clk);
    end
    in_valid = 1'b0;
    col_end  = 1'b0;
    row_end  = 1'b0;
  endtask

  // Waits for done; with junk=1 hammers the input with full beats while busy.
  task automatic wait_done(input string tag, input bit junk);
    int n;
    n = 0;
    while (!done && n < 300) begin
      if (junk) begin
        in_valid = 1'b1;
        in_data  = DW'($urandom_range(0, 255));
        col_end  = 1'b1;
        row_end  = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    col_end  = 1'b0;
    row_end  = 1'b0;
    #1;
    chk({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic check_job(input string tag, input int lat);
    int n;
    chk({tag, "_count"}, obs_d.size(), exp_q.size());
    n = (obs_d.size() < exp_q.size()) ? obs_d.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), obs_d[i], exp_q[i]);
      chk($sformatf("%s_crow%0d", tag, i), obs_cr[i], exp_cr[i]);
      chk($sformatf("%s_legal%0d", tag, i), obs_lg[i], exp_legal);
    end
    chk({tag, "_first_lat"}, first_ov - busy_rise, lat);
    chk({tag, "_done_gap"}, done_cyc - last_ov, 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  task automatic load_2x3_3x2();
    push(1, 0, 0); push(2, 0, 0); push(3, 1, 0);
    push(4, 0, 0); push(5, 0, 0); push(6, 1, 1);
    push(7, 0, 0);  push(8, 1, 0);
    push(9, 0, 0);  push(10, 1, 0);
    push(11, 0, 0); push(12, 1, 1);
  endtask

  task automatic expect_2x3_3x2();
    exp_legal = 1'b1;
    expect_el(58, 0); expect_el(64, 1); expect_el(139, 0); expect_el(154, 1);
  endtask

  task automatic expect_reject();
    exp_legal = 1'b0;
    expect_el(0, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_flags", {is_legal, change_row, done}, 3'b000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 2x3 * 3x2 with idle gaps between beats.
    clear_job(); load_2x3_3x2(); expect_2x3_3x2();
    send_beats(1'b1); wait_done("mm23", 1'b0); check_job("mm23", 4);

    // 4x4 of -128 squared: every element is 4*16384.
    clear_job();
    push_const(4, 4, -128); push_const(4, 4, -128);
    exp_legal = 1'b1;
    for (int i = 0; i < 16; i++) expect_el(65536, (i % 4) == 3);
    send_beats(1'b0); wait_done("neg4", 1'b0); check_job("neg4", 5);

    // Shape mismatch: A 2x3, B 2x2.
    clear_job();
    push_const(2, 3, 1); push_const(2, 2, 1);
    expect_reject();
    send_beats(1'b0); wait_done("shape", 1'b0); check_job("shape", 1);

    // Ragged A (3 then 2 elements), B 3x1 so only the ragged row can reject.
    clear_job();
    push(1, 0, 0); push(2, 0, 0); push(3, 1, 0);
    push(4, 0, 0); push(5, 1, 1);
    push_const(3, 1, 1);
    expect_reject();
    send_beats(1'b0); wait_done("ragged", 1'b0); check_job("ragged", 1);

    // Row of five elements at MAXN=4.
    clear_job();
    push(1, 0, 0); push(2, 0, 0); push(3, 0, 0); push(4, 0, 0); push(5, 1, 1);
    push_const(4, 1, 1);
    expect_reject();
    send_beats(1'b0); wait_done("longrow", 1'b0); check_job("longrow", 1);

    // Five rows of one element, B 1x1: only the row count is illegal.
    clear_job();
    push_const(5, 1, 2); push_const(1, 1, 3);
    expect_reject();
    send_beats(1'b0); wait_done("manyrow", 1'b0); check_job("manyrow", 1);

    // 1x1 with beats thrown at the busy engine.
    clear_job();
    push(-5, 1, 1); push(7, 1, 1);
    exp_legal = 1'b1;
    expect_el(-35, 1);
    send_beats(1'b1); wait_done("one", 1'b1); check_job("one", 2);

    // Abort during CALC, then rerun the same job.
    clear_job(); load_2x3_3x2();
    send_beats(1'b0);
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_busy_seen", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy_in_rst", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_job();
    repeat (20) @(negedge clk);
    chk("abort_no_outputs", obs_d.size(), 0);
    chk("abort_no_done", done_cnt, 0);
    clear_job(); load_2x3_3x2(); expect_2x3_3x2();
    send_beats(1'b1); wait_done("rerun", 1'b0); check_job("rerun", 4);

    chk("idle_outputs_zero", idle_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
